// File: rtl/serial_frame_tx_if.sv
// -----------------------------------------------------------------------------
// serial_frame_tx_if
// Parallel payload handshake into serial_frame_tx.
//   i_data  : payload word (DATA_W bits), producer -> transmitter
//   i_valid : i_data valid, producer -> transmitter
//   o_ready : transmitter FIFO not full, transmitter -> producer
// Modports: master = payload producer, slave = serial_frame_tx.
// -----------------------------------------------------------------------------
interface serial_frame_tx_if #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] i_data;
   logic              i_valid;
   logic              o_ready;

   modport master (output i_data, output i_valid, input o_ready);
   modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
// Buffers parallel payload words in a small FIFO and sends each one as a
// serial frame: SYNC_WORD (bit 0 first) followed by the payload (LSB first),
// then GAP_LEN zero cycles in GAP plus one IDLE cycle before the next frame.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   bus (slave)    i_data / i_valid / o_ready payload handshake
//   s_data         serial line, registered
//   o_busy         transmitter not idle, registered
//   o_frame_start  pulse while s_data carries SYNC_WORD[0], registered
//   o_frame_done   pulse while s_data carries the last frame bit, registered
//
// Build option:
//   SERIAL_FRAME_TX_PARITY_EN  appends an even-parity bit (XOR of payload)
//                              after the payload; o_frame_done moves to it.
// -----------------------------------------------------------------------------
module serial_frame_tx #(
   parameter int                DATA_W     = 8,
   parameter int                SYNC_W     = 9,
   parameter logic [SYNC_W-1:0] SYNC_WORD  = 9'b101000111,
   parameter int                FIFO_DEPTH = 4,
   parameter int                GAP_LEN    = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   serial_frame_tx_if.slave bus,
   output logic             s_data,
   output logic             o_busy,
   output logic             o_frame_start,
   output logic             o_frame_done
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_F_W = $clog2(FIFO_DEPTH + 1);
`ifdef SERIAL_FRAME_TX_PARITY_EN
   // index DATA_W inside DATA is the parity bit
   localparam int LAST_IDX = DATA_W;
`else
   localparam int LAST_IDX = DATA_W - 1;
`endif
   localparam int CNT_M1  = (SYNC_W > LAST_IDX + 1) ? SYNC_W : LAST_IDX + 1;
   localparam int CNT_MAX = (CNT_M1 > GAP_LEN) ? CNT_M1 : GAP_LEN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // State names what s_data is currently showing.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_F_W-1:0] r_count;

   state_t             r_state;
   state_t             w_nxt_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_nxt_cnt;
   logic [DATA_W-1:0]  r_payload;

   logic               w_ready;
   logic               w_push;
   logic               w_pop;
   logic               w_nxt_sdata;
   logic               w_nxt_done;

`ifdef SERIAL_FRAME_TX_PARITY_EN
   logic               r_parity;

   function automatic logic even_parity(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction
`endif

   assign w_ready     = (r_count != CNT_F_W'(FIFO_DEPTH));
   assign w_push      = bus.i_valid & w_ready;
   assign bus.o_ready = w_ready;

   // Payload FIFO: write/read pointers wrap naturally, occupancy kept separately.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_F_W{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= {DATA_W{1'b0}};
         end
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= bus.i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_F_W'(1);
            2'b01:   r_count <= r_count - CNT_F_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FSM next state, bit counter and pop request.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Pop only from IDLE, so a word pushed at edge N leaves at N+1 earliest.
            if (r_count != {CNT_F_W{1'b0}}) begin
               w_pop       = 1'b1;
               w_nxt_state = ST_SYNC;
               w_nxt_cnt   = {CNT_W{1'b0}};
            end else begin
               w_nxt_state = ST_IDLE;
               w_nxt_cnt   = {CNT_W{1'b0}};
            end
         end
         ST_SYNC: begin
            if (r_cnt == CNT_W'(SYNC_W - 1)) begin
               w_nxt_state = ST_DATA;
               w_nxt_cnt   = {CNT_W{1'b0}};
            end else begin
               w_nxt_cnt   = r_cnt + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (r_cnt == CNT_W'(LAST_IDX)) begin
               w_nxt_state = ST_GAP;
               w_nxt_cnt   = {CNT_W{1'b0}};
            end else begin
               w_nxt_cnt   = r_cnt + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (r_cnt == CNT_W'(GAP_LEN - 1)) begin
               w_nxt_state = ST_IDLE;
               w_nxt_cnt   = {CNT_W{1'b0}};
            end else begin
               w_nxt_cnt   = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Next serial bit and done flag, derived from the state being entered.
   always_comb begin
      w_nxt_sdata = 1'b0;
      case (w_nxt_state)
         ST_SYNC: w_nxt_sdata = |(SYNC_WORD & (SYNC_W'(1) << w_nxt_cnt));
         ST_DATA: begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
            if (w_nxt_cnt == CNT_W'(DATA_W)) begin
               w_nxt_sdata = r_parity;
            end else begin
               w_nxt_sdata = |(r_payload & (DATA_W'(1) << w_nxt_cnt));
            end
`else
            w_nxt_sdata = |(r_payload & (DATA_W'(1) << w_nxt_cnt));
`endif
         end
         default: w_nxt_sdata = 1'b0;
      endcase
      w_nxt_done = (w_nxt_state == ST_DATA) && (w_nxt_cnt == CNT_W'(LAST_IDX));
   end

   // FSM state register and registered serial outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_cnt         <= {CNT_W{1'b0}};
         r_payload     <= {DATA_W{1'b0}};
         s_data        <= 1'b0;
         o_busy        <= 1'b0;
         o_frame_start <= 1'b0;
         o_frame_done  <= 1'b0;
      end else begin
         r_state       <= w_nxt_state;
         r_cnt         <= w_nxt_cnt;
         s_data        <= w_nxt_sdata;
         o_busy        <= (w_nxt_state != ST_IDLE);
         o_frame_start <= w_pop;
         o_frame_done  <= w_nxt_done;
         if (w_pop) begin
            r_payload <= r_mem[r_rd_ptr];
         end else begin
            r_payload <= r_payload;
         end
      end
   end

`ifdef SERIAL_FRAME_TX_PARITY_EN
   // Parity of the popped word, captured alongside the payload.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_parity <= 1'b0;
      end else if (w_pop) begin
         r_parity <= even_parity(r_mem[r_rd_ptr]);
      end else begin
         r_parity <= r_parity;
      end
   end
`endif

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
// Self-checking bench for serial_frame_tx. The reference model keeps a queue
// of accepted words and a queue of future line cycles; whenever the line goes
// quiet and a word is waiting, a whole frame (sync, payload, optional parity,
// gap, idle) is appended. Every cycle all outputs are compared to it.
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;
   localparam int                DATA_W     = 8;
   localparam int                SYNC_W     = 9;
   localparam logic [SYNC_W-1:0] SYNC_WORD  = 9'b101000111;
   localparam int                FIFO_DEPTH = 4;
   localparam int                GAP_LEN    = 2;

   logic clk;
   logic rst_n;
   logic s_data;
   logic o_busy;
   logic o_frame_start;
   logic o_frame_done;

   serial_frame_tx_if #(.DATA_W(DATA_W)) bus_if ();

   serial_frame_tx #(
      .DATA_W(DATA_W), .SYNC_W(SYNC_W), .SYNC_WORD(SYNC_WORD),
      .FIFO_DEPTH(FIFO_DEPTH), .GAP_LEN(GAP_LEN)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus_if), .s_data(s_data),
      .o_busy(o_busy), .o_frame_start(o_frame_start), .o_frame_done(o_frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic b;
      logic st;
      logic dn;
      logic bz;
      int   idx;
   } ent_t;

   ent_t              line[$];
   ent_t              cur;
   logic [DATA_W-1:0] q[$];
   logic [SYNC_W-1:0] sync_v;
   logic [SYNC_W-1:0] win;
   int                hits;
   int                n_vec;
   int                n_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic ent_t mk(input logic b, input logic st, input logic dn,
                               input logic bz, input int idx);
      ent_t e;
      e.b = b; e.st = st; e.dn = dn; e.bz = bz; e.idx = idx;
      return e;
   endfunction

   task automatic build_frame(input logic [DATA_W-1:0] w);
      logic par_en;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      par_en = 1'b1;
`else
      par_en = 1'b0;
`endif
      // sync word goes out bit 0 first, payload LSB first
      for (int i = 0; i < SYNC_W; i++)
         line.push_back(mk(sync_v[i], i == 0, 1'b0, 1'b1, i));
      for (int i = 0; i < DATA_W; i++)
         line.push_back(mk(w[i], 1'b0, (i == DATA_W - 1) && !par_en, 1'b1, SYNC_W + i));
      if (par_en)
         line.push_back(mk(^w, 1'b0, 1'b1, 1'b1, SYNC_W + DATA_W));
      for (int i = 0; i < GAP_LEN; i++)
         line.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, -1));
      line.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, -1));
   endtask

   task automatic model_reset();
      q.delete();
      line.delete();
      cur = mk(1'b0, 1'b0, 1'b0, 1'b0, -1);
   endtask

   task automatic model_edge();
      logic rdy;
      if (!rst_n) begin
         model_reset();
      end else begin
         rdy = (q.size() < FIFO_DEPTH);
         if (line.size() == 0 && q.size() != 0) build_frame(q.pop_front());
         if (line.size() != 0) cur = line.pop_front();
         else cur = mk(1'b0, 1'b0, 1'b0, 1'b0, -1);
         if (bus_if.i_valid && rdy) q.push_back(bus_if.i_data);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      win = {s_data, win[SYNC_W-1:1]};
      if (win == sync_v) hits++;
      check("s_data", 32'(s_data), 32'(cur.b));
      check("busy", 32'(o_busy), 32'(cur.bz));
      check("frame_start", 32'(o_frame_start), 32'(cur.st));
      check("frame_done", 32'(o_frame_done), 32'(cur.dn));
      check("ready", 32'(bus_if.o_ready), 32'(q.size() < FIFO_DEPTH));
   endtask

   task automatic push_one(input logic [DATA_W-1:0] d);
      bus_if.i_data  = d;
      bus_if.i_valid = 1'b1;
      step();
      bus_if.i_valid = 1'b0;
   endtask

   initial begin : main
      logic [16:0] seq;
      logic [16:0] exp_a5;
      int          k;
      int          h0;
      logic        found;

      n_vec = 0; n_err = 0; hits = 0;
      sync_v = SYNC_WORD;
      win = '0;
      exp_a5 = {8'hA5, SYNC_WORD};
      bus_if.i_valid = 1'b0;
      bus_if.i_data  = '0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) step();
      #2 rst_n = 1'b1;
      repeat (3) step();

      // single frame of 8'hA5
      push_one(8'hA5);
      for (int i = 0; i < 17; i++) begin
         step();
         seq[i] = s_data;
      end
      check("a5_sequence", 32'(seq), 32'(exp_a5));
      repeat (12) step();

      // all-zero payload: the sync pattern should appear exactly once
      h0 = hits;
      push_one(8'h00);
      repeat (30) step();
      check("sync_hits", 32'(hits - h0), 32'd1);

      // hold valid with 1..6 while busy; acceptance follows model occupancy
      k = 1;
      for (int c = 0; c < 200 && k <= 6; c++) begin
         logic pre;
         bus_if.i_data  = DATA_W'(k);
         bus_if.i_valid = 1'b1;
         pre = (q.size() < FIFO_DEPTH);
         step();
         if (pre) k++;
      end
      bus_if.i_valid = 1'b0;
      check("fill_count", 32'(k), 32'd7);
      repeat (150) step();

      // back-to-back pushes from idle: second push coincides with the pop
      push_one(8'h3C);
      push_one(8'hC3);
      repeat (60) step();

      // parity-relevant payloads
      push_one(8'h07);
      push_one(8'h03);
      repeat (60) step();

      // reset in the middle of payload bit 3 with another word queued
      push_one(8'h5A);
      push_one(8'h96);
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         step();
         if (cur.idx == SYNC_W + 3) found = 1'b1;
      end
      check("reach_data_bit3", 32'(found), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_s_data", 32'(s_data), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_start", 32'(o_frame_start), 32'd0);
      check("rst_done", 32'(o_frame_done), 32'd0);
      check("rst_ready", 32'(bus_if.o_ready), 32'd1);
      repeat (2) step();
      #2 rst_n = 1'b1;
      repeat (30) step();

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         bus_if.i_data  = DATA_W'($urandom);
         bus_if.i_valid = ($urandom_range(0, 5) == 0);
         step();
      end
      bus_if.i_valid = 1'b0;
      repeat (120) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
